// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// scoreboard stage entry, forward-select encoding and select-width helper.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned RDY_W      = 4;
    localparam int unsigned FWD_SEL_RF = 0;

    typedef struct packed {
        logic             valid;
        logic [4:0]       wa;
        logic             wen;
        logic [RDY_W-1:0] rdy;
    } stage_entry_t;

    function automatic int unsigned sel_width(input int unsigned fwd_stages);
        return $clog2(fwd_stages + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX side bundle of the hazard controller: decode inputs, forwarding data
// and the stall/forward results. slave = controller, master = pipeline.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned CNT_W      = 32
);
    localparam int unsigned SEL_W = pipe_hazard_ctrl_pkg::sel_width(FWD_STAGES);

    logic                       id_valid;
    logic [NUM_SRC*5-1:0]       id_rs;
    logic [NUM_SRC-1:0]         id_rs_used;
    logic [4:0]                 id_wa;
    logic                       id_wen;
    logic                       id_is_load;
    logic                       flush;
    logic [NUM_SRC*XLEN-1:0]    ex_rf_data;
    logic [FWD_STAGES*XLEN-1:0] stage_data;
    logic                       stall;
    logic                       ex_bubble;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic [NUM_SRC*XLEN-1:0]    ex_operand;
    logic [CNT_W-1:0]           stall_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_wa, id_wen, id_is_load,
               flush, ex_rf_data, stage_data,
        input  stall, ex_bubble, fwd_sel, ex_operand, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_wa, id_wen, id_is_load,
               flush, ex_rf_data, stage_data,
        output stall, ex_bubble, fwd_sel, ex_operand, stall_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Priority match of one source register against the stage scoreboard;
// reports the youngest (lowest-index) matching writer and its ready stage.
module hazard_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned FIRST      = 0,
    parameter int unsigned SEL_W      = 2
) (
    input  stage_entry_t     stg [FWD_STAGES+1],
    input  logic [4:0]       src,
    input  logic             used,
    output logic             hit,
    output logic [SEL_W-1:0] idx,
    output logic [RDY_W-1:0] rdy
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        rdy = '0;
        for (int unsigned k = FIRST; k <= FWD_STAGES; k++) begin
            if (!hit && used && stg[k].valid && stg[k].wen &&
                stg[k].wa != 5'd0 && stg[k].wa == src) begin
                hit = 1'b1;
                idx = SEL_W'(k);
                rdy = stg[k].rdy;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall and operand forwarding control for an in-order pipeline with
// FWD_STAGES post-EX stages; tracks in-flight writers in a shifting scoreboard.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned CNT_W      = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned SEL_W = sel_width(FWD_STAGES);

    stage_entry_t             stg [FWD_STAGES+1];
    stage_entry_t             id_entry;
    logic [NUM_SRC*5-1:0]     ex_rs;
    logic [NUM_SRC-1:0]       ex_rs_used;
    logic [NUM_SRC-1:0]       id_hit, ex_hit, src_stall;
    logic [SEL_W-1:0]         id_idx [NUM_SRC];
    logic [SEL_W-1:0]         ex_idx [NUM_SRC];
    logic [RDY_W-1:0]         id_rdy [NUM_SRC];
    logic [RDY_W-1:0]         ex_rdy [NUM_SRC];
    logic                     stall, issue;
    logic [CNT_W-1:0]         stall_count;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic [NUM_SRC*XLEN-1:0]  ex_operand;

    // ID sources check S0..SD for stalls; EX sources forward from S1..SD only.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        hazard_match #(.FWD_STAGES(FWD_STAGES), .FIRST(0), .SEL_W(SEL_W)) u_id_match (
            .stg (stg),
            .src (bus.id_rs[gi*5 +: 5]),
            .used(bus.id_rs_used[gi]),
            .hit (id_hit[gi]),
            .idx (id_idx[gi]),
            .rdy (id_rdy[gi])
        );
        hazard_match #(.FWD_STAGES(FWD_STAGES), .FIRST(1), .SEL_W(SEL_W)) u_ex_match (
            .stg (stg),
            .src (ex_rs[gi*5 +: 5]),
            .used(ex_rs_used[gi]),
            .hit (ex_hit[gi]),
            .idx (ex_idx[gi]),
            .rdy (ex_rdy[gi])
        );
        assign src_stall[gi] = id_hit[gi] && (32'(id_idx[gi]) + 32'd1 < 32'(id_rdy[gi]));
    end

    always_comb begin
        id_entry       = '0;
        id_entry.valid = 1'b1;
        id_entry.wa    = bus.id_wa;
        id_entry.wen   = bus.id_wen;
        id_entry.rdy   = bus.id_is_load ? RDY_W'(1 + LOAD_LAT) : RDY_W'(1);
    end

    assign stall = bus.id_valid && (|src_stall) && !bus.flush;
    assign issue = bus.id_valid && !stall && !bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k <= FWD_STAGES; k++) stg[k] <= '0;
            ex_rs       <= '0;
            ex_rs_used  <= '0;
            stall_count <= '0;
        end else begin
            stg[0] <= issue ? id_entry : '0;
            for (int unsigned k = 1; k <= FWD_STAGES; k++) stg[k] <= stg[k-1];
            if (issue) ex_rs <= bus.id_rs;
            ex_rs_used <= issue ? bus.id_rs_used : '0;
            if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
        end
    end

    always_comb begin
        fwd_sel    = '0;
        ex_operand = bus.ex_rf_data;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ex_hit[i]) fwd_sel[i*SEL_W +: SEL_W] = ex_idx[i];
            for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
                if (ex_hit[i] && ex_idx[i] == SEL_W'(k))
                    ex_operand[i*XLEN +: XLEN] = bus.stage_data[(k-1)*XLEN +: XLEN];
            end
        end
    end

    // The stall rule must keep forwarding away from stages whose data is not ready yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++)
                assert (!ex_hit[i] || 32'(ex_idx[i]) >= 32'(ex_rdy[i]));
        end
    end

    assign bus.stall       = stall;
    assign bus.ex_bubble   = !stg[0].valid;
    assign bus.fwd_sel     = fwd_sel;
    assign bus.ex_operand  = ex_operand;
    assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default configuration plus a deep
// (3 stage, 2 cycle load, 4-bit counter) instance driven side by side.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.XLEN(32), .NUM_SRC(2), .FWD_STAGES(2), .CNT_W(32)) ifa ();
    pipe_hazard_ctrl_if #(.XLEN(32), .NUM_SRC(2), .FWD_STAGES(3), .CNT_W(4))  ifb ();

    pipe_hazard_ctrl #(.XLEN(32), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_LAT(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    pipe_hazard_ctrl #(.XLEN(32), .NUM_SRC(2), .FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                           input logic [1:0] used, input logic [4:0] wa, input logic wen,
                           input logic ld);
        ifa.id_valid   = v;
        ifa.id_rs      = {rs1, rs0};
        ifa.id_rs_used = used;
        ifa.id_wa      = wa;
        ifa.id_wen     = wen;
        ifa.id_is_load = ld;
        ifa.flush      = 1'b0;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                           input logic [1:0] used, input logic [4:0] wa, input logic wen,
                           input logic ld);
        ifb.id_valid   = v;
        ifb.id_rs      = {rs1, rs0};
        ifb.id_rs_used = used;
        ifb.id_wa      = wa;
        ifb.id_wen     = wen;
        ifb.id_is_load = ld;
        ifb.flush      = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        drive_a(0, 0, 0, 2'b00, 0, 0, 0);
        drive_b(0, 0, 0, 2'b00, 0, 0, 0);
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive_a(0, 0, 0, 2'b00, 0, 0, 0);
        drive_b(0, 0, 0, 2'b00, 0, 0, 0);
        tick;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", ifa.stall); end
        checks++; if (ifa.ex_bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble: got %b expected 1", ifa.ex_bubble); end
        checks++; if (ifa.fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd_sel: got %h expected 0", ifa.fwd_sel); end
        checks++; if (ifa.ex_operand !== 64'h2222_2222_1111_1111) begin errors++; $display("FAIL reset_operand: got %h expected 2222222211111111", ifa.ex_operand); end
        checks++; if (ifa.stall_count !== 32'd0) begin errors++; $display("FAIL reset_count_a: got %0d expected 0", ifa.stall_count); end
        checks++; if (ifb.stall_count !== 4'd0) begin errors++; $display("FAIL reset_count_b: got %0d expected 0", ifb.stall_count); end
        rst = 1'b1;
    endtask

    task automatic test_forward;
        do_reset;
        drive_a(1, 0, 0, 2'b00, 5, 1, 0);
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL fwd_stall_first: got %b expected 0", ifa.stall); end
        tick;
        drive_a(1, 5, 5, 2'b11, 6, 1, 0);
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL fwd_stall_use: got %b expected 0", ifa.stall); end
        tick;
        drive_a(0, 0, 0, 2'b00, 0, 0, 0);
        #1;
        checks++; if (ifa.fwd_sel !== 4'b0101) begin errors++; $display("FAIL fwd_sel_s1: got %h expected 5", ifa.fwd_sel); end
        checks++; if (ifa.ex_operand !== 64'h0000_1234_0000_1234) begin errors++; $display("FAIL fwd_operand: got %h expected 0000123400001234", ifa.ex_operand); end
        checks++; if (ifa.ex_bubble !== 1'b0) begin errors++; $display("FAIL fwd_bubble: got %b expected 0", ifa.ex_bubble); end
    endtask

    task automatic test_load_use;
        do_reset;
        drive_a(1, 0, 0, 2'b00, 5, 1, 1);
        tick;
        drive_a(1, 5, 5, 2'b01, 6, 1, 0);
        #1;
        checks++; if (ifa.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", ifa.stall); end
        tick;
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL lu_stall_end: got %b expected 0", ifa.stall); end
        checks++; if (ifa.ex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b expected 1", ifa.ex_bubble); end
        tick;
        drive_a(0, 0, 0, 2'b00, 0, 0, 0);
        #1;
        checks++; if (ifa.fwd_sel !== 4'b0010) begin errors++; $display("FAIL lu_fwd_sel: got %h expected 2", ifa.fwd_sel); end
        checks++; if (ifa.ex_operand !== 64'h2222_2222_dead_beef) begin errors++; $display("FAIL lu_operand: got %h expected 22222222deadbeef", ifa.ex_operand); end
        checks++; if (ifa.stall_count !== 32'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", ifa.stall_count); end
    endtask

    task automatic test_x0_youngest;
        do_reset;
        drive_a(1, 0, 0, 2'b00, 0, 1, 1);
        tick;
        drive_a(1, 0, 0, 2'b11, 6, 1, 0);
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b expected 0", ifa.stall); end
        tick;
        drive_a(0, 0, 0, 2'b00, 0, 0, 0);
        #1;
        checks++; if (ifa.fwd_sel !== 4'b0000) begin errors++; $display("FAIL x0_fwd_sel: got %h expected 0", ifa.fwd_sel); end
        checks++; if (ifa.ex_operand !== 64'h2222_2222_1111_1111) begin errors++; $display("FAIL x0_operand: got %h expected 2222222211111111", ifa.ex_operand); end
        do_reset;
        drive_a(1, 0, 0, 2'b00, 7, 1, 0);
        tick;
        drive_a(1, 0, 0, 2'b00, 7, 1, 0);
        tick;
        drive_a(1, 7, 7, 2'b11, 8, 1, 0);
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL young_stall: got %b expected 0", ifa.stall); end
        tick;
        drive_a(0, 0, 0, 2'b00, 0, 0, 0);
        #1;
        checks++; if (ifa.fwd_sel !== 4'b0101) begin errors++; $display("FAIL young_fwd_sel: got %h expected 5", ifa.fwd_sel); end
    endtask

    task automatic test_gating;
        do_reset;
        drive_a(1, 0, 0, 2'b00, 5, 1, 1);
        tick;
        drive_a(1, 5, 5, 2'b00, 6, 1, 0);
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL unused_src_stall: got %b expected 0", ifa.stall); end
        do_reset;
        drive_a(1, 0, 0, 2'b00, 5, 0, 1);
        tick;
        drive_a(1, 5, 5, 2'b11, 6, 1, 0);
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL nowen_stall: got %b expected 0", ifa.stall); end
    endtask

    task automatic test_flush;
        do_reset;
        drive_a(1, 0, 0, 2'b00, 5, 1, 1);
        tick;
        drive_a(1, 5, 0, 2'b01, 6, 1, 0);
        ifa.flush = 1'b1;
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", ifa.stall); end
        tick;
        drive_a(0, 0, 0, 2'b00, 0, 0, 0);
        #1;
        checks++; if (ifa.ex_bubble !== 1'b1) begin errors++; $display("FAIL flush_bubble: got %b expected 1", ifa.ex_bubble); end
        checks++; if (ifa.stall_count !== 32'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", ifa.stall_count); end
    endtask

    task automatic test_reset_mid_stall;
        do_reset;
        drive_a(1, 0, 0, 2'b00, 5, 1, 1);
        tick;
        drive_a(1, 5, 0, 2'b01, 6, 1, 0);
        #1;
        checks++; if (ifa.stall !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %b expected 1", ifa.stall); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL mid_stall_in_reset: got %b expected 0", ifa.stall); end
        checks++; if (ifa.ex_bubble !== 1'b1) begin errors++; $display("FAIL mid_bubble_in_reset: got %b expected 1", ifa.ex_bubble); end
        tick;
        rst = 1'b1;
        #1;
        checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL mid_stall_post: got %b expected 0", ifa.stall); end
        checks++; if (ifa.stall_count !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", ifa.stall_count); end
    endtask

    task automatic test_deep;
        int nstall;
        do_reset;
        drive_b(1, 0, 0, 2'b00, 9, 1, 1);
        #1;
        checks++; if (ifb.stall !== 1'b0) begin errors++; $display("FAIL deep_stall_lw: got %b expected 0", ifb.stall); end
        tick;
        drive_b(1, 9, 0, 2'b01, 10, 1, 0);
        #1;
        checks++; if (ifb.stall !== 1'b1) begin errors++; $display("FAIL deep_stall_c1: got %b expected 1", ifb.stall); end
        tick;
        #1;
        checks++; if (ifb.stall !== 1'b1) begin errors++; $display("FAIL deep_stall_c2: got %b expected 1", ifb.stall); end
        tick;
        #1;
        checks++; if (ifb.stall !== 1'b0) begin errors++; $display("FAIL deep_stall_c3: got %b expected 0", ifb.stall); end
        tick;
        drive_b(0, 0, 0, 2'b00, 0, 0, 0);
        #1;
        checks++; if (ifb.fwd_sel !== 4'b0011) begin errors++; $display("FAIL deep_fwd_sel: got %h expected 3", ifb.fwd_sel); end
        checks++; if (ifb.ex_operand !== 64'h4444_4444_3333_0003) begin errors++; $display("FAIL deep_operand: got %h expected 4444444433330003", ifb.ex_operand); end
        checks++; if (ifb.stall_count !== 4'd2) begin errors++; $display("FAIL deep_count: got %0d expected 2", ifb.stall_count); end

        do_reset;
        nstall = 0;
        for (int n = 0; n < 10; n++) begin
            drive_b(1, 0, 0, 2'b00, 9, 1, 1);
            #1;
            if (ifb.stall === 1'b1) nstall++;
            tick;
            drive_b(1, 9, 0, 2'b01, 10, 0, 0);
            for (int c = 0; c < 3; c++) begin
                #1;
                if (ifb.stall === 1'b1) nstall++;
                tick;
            end
        end
        drive_b(0, 0, 0, 2'b00, 0, 0, 0);
        #1;
        checks++; if (nstall !== 20) begin errors++; $display("FAIL sat_stall_cycles: got %0d expected 20", nstall); end
        checks++; if (ifb.stall_count !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d expected 15", ifb.stall_count); end
    endtask

    initial begin
        ifa.ex_rf_data = 64'h2222_2222_1111_1111;
        ifa.stage_data = 64'hdead_beef_0000_1234;
        ifb.ex_rf_data = 64'h4444_4444_5555_5555;
        ifb.stage_data = 96'h3333_0003_2222_0002_1111_0001;
        test_reset;
        test_forward;
        test_load_use;
        test_x0_youngest;
        test_gating;
        test_flush;
        test_reset_mid_stall;
        test_deep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete within 50000 time units");
        $fatal(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of source operands per instruction.
REQ-003 SHALL have parameter FWD_STAGES, default 2, number of post-EX stages S1..SD (D=FWD_STAGES); SD is writeback.
REQ-004 SHALL have parameter LOAD_LAT, default 1, extra stages after S1 before load data is valid; 1+LOAD_LAT <= FWD_STAGES.
REQ-005 SHALL have parameter CNT_W, default 32, stall counter width; SEL_W = clog2(FWD_STAGES+1).
REQ-006 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: id_valid in 1, ID holds a real instruction; id_rs in NUM_SRC*5, source register addresses, source 0 at LSBs; id_rs_used in NUM_SRC, source is read.
REQ-008 SHALL have ports: id_wa in 5, destination register; id_wen in 1, writes a register; id_is_load in 1, result comes from memory.
REQ-009 SHALL have ports: flush in 1, taken branch/jump resolved in EX; ex_rf_data in NUM_SRC*XLEN, register-file values of the EX instruction; stage_data in FWD_STAGES*XLEN, result of Sk, S1 at LSBs.
REQ-010 SHALL have ports: stall out 1, hold PC and IF/ID; ex_bubble out 1, EX slot is a bubble; fwd_sel out NUM_SRC*SEL_W, 0 = regfile, k = Sk; ex_operand out NUM_SRC*XLEN, forwarded operands; stall_count out CNT_W.

Function
REQ-011 SHALL track stages S0 (EX)..SD, each entry {valid, wa, wen, rdy}, where rdy = 1 for non-loads and 1+LOAD_LAT for loads.
REQ-012 SHALL shift every entry Sk to Sk+1 each cycle, unconditionally; SD retires.
REQ-013 SHALL load S0 from ID when id_valid, stall=0 and flush=0; otherwise S0.valid=0 and ex_bubble=1 next cycle.
REQ-014 SHALL register id_rs/id_rs_used into the EX operand context under the same condition as S0.
REQ-015 SHALL treat a matching writer as valid && wen && wa!=0 && wa==source; register x0 is never matched.
REQ-016 SHALL assert stall, combinationally, when a used ID source has a youngest matching writer in Sk (k in 0..D-1) with k+1 < rdy; stall lasts exactly rdy-(k+1) cycles.
REQ-017 SHALL make flush override stall: stall=0 in the flush cycle, and the ID instruction is dropped as a bubble.
REQ-018 SHALL, for each used EX source, set fwd_sel to the smallest k in 1..D with a matching writer in Sk, else 0; youngest writer wins.
REQ-019 SHALL drive ex_operand[i] combinationally from stage_data[fwd_sel[i]], or from ex_rf_data[i] when fwd_sel[i]=0.
REQ-020 SHALL never select an Sk with k < rdy; the stall rule guarantees this.
REQ-021 SHALL increment stall_count on each cycle with stall=1, saturating at 2^CNT_W-1 (no wrap).
REQ-022 SHALL have no latency from ID inputs to stall, and 1 cycle from ID to EX forwarding outputs.

Reset
REQ-023 SHALL, while rst=0 and asynchronously, clear all entries and the EX context to valid=0, set stall_count=0, and hold stall=0, ex_bubble=1, fwd_sel=0 and ex_operand=ex_rf_data.
REQ-024 SHALL treat reset mid-stall as discarding all in-flight tracking; the first post-reset cycle has no hazards.

Structure
REQ-025 SHALL place stage-entry struct fields, the SEL_W computation and the FWD_SEL_RF=0 constant in the shared core package.
REQ-026 SHALL have one natural sub-module, hazard_match, per source: a priority match over S0..SD returning the youngest index and its rdy.

Verification
REQ-027 SHALL verify with defaults: add x5 then add x6,x5,x5 -> stall=0, next cycle fwd_sel={1,1}, ex_operand=stage_data S1 value 0x0000_1234.
REQ-028 SHALL verify load-use: lw x5 then add x6,x5 -> stall=1 for 1 cycle, ex_bubble=1, then fwd_sel[0]=2, stall_count=1.
REQ-029 SHALL verify x0 and youngest-wins: writes to x0 -> fwd_sel=0; x7 written in both S1 and S2 -> fwd_sel=1.
REQ-030 SHALL verify flush during load-use stall -> stall=0 that cycle, ex_bubble=1 next cycle, stall_count unchanged.
REQ-031 SHALL verify FWD_STAGES=3, LOAD_LAT=2: lw x9 then use x9 -> stall 2 cycles, then fwd_sel=3; with CNT_W=4, 20 stall cycles -> stall_count=15.
